// File: rtl/riscv_state_pkg.sv
// Shared encodings for the execute-stage result collector: source IDs and FSM states.
package riscv_state_pkg;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_BU  = 2'd1,
    SRC_MUL = 2'd2,
    SRC_DIV = 2'd3
  } ex_src_e;

  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } ex_state_e;

endpackage

// File: rtl/riscv_ex_result_collect.sv
// Collects one result per cycle from the execute units and registers it toward the memory
// stage, parking a single result in a hold buffer while memory is stalled.
module riscv_ex_result_collect
  import riscv_state_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_stall_i,
  input  logic             alu_bubble_i,
  input  logic [XLEN-1:0]  alu_r_i,
  input  logic             bu_bubble_i,
  input  logic [XLEN-1:0]  bu_r_i,
  input  logic             mul_bubble_i,
  input  logic [XLEN-1:0]  mul_r_i,
  input  logic             div_bubble_i,
  input  logic [XLEN-1:0]  div_r_i,
  output logic [XLEN-1:0]  ex_r_o,
  output logic             ex_bubble_o,
  output logic [1:0]       ex_src_o,
  output logic             ex_stall_o,
  output logic             ex_err_o,
  output logic [CNT_W-1:0] ex_cnt_o
);

  // Fixed priority MUL > DIV > BU > ALU; returns {src, result}.
  function automatic logic [XLEN+1:0] prio_sel(
    input logic            alu_v,
    input logic            bu_v,
    input logic            mul_v,
    input logic            div_v,
    input logic [XLEN-1:0] alu_r,
    input logic [XLEN-1:0] bu_r,
    input logic [XLEN-1:0] mul_r,
    input logic [XLEN-1:0] div_r
  );
    logic [XLEN+1:0] res;
    if (mul_v)      res = {SRC_MUL, mul_r};
    else if (div_v) res = {SRC_DIV, div_r};
    else if (bu_v)  res = {SRC_BU, bu_r};
    else            res = {SRC_ALU, alu_r};
    if (!alu_v && !bu_v && !mul_v && !div_v) res = {SRC_ALU, alu_r};
    return res;
  endfunction

  ex_state_e       state_q;
  logic [XLEN-1:0] ex_r_q;
  ex_src_e         ex_src_q;
  logic            ex_bubble_q;
  logic            ex_stall_q;
  logic            ex_err_q;
  logic [CNT_W-1:0] ex_cnt_q;
  logic [XLEN-1:0] hold_r_q;
  ex_src_e         hold_src_q;

  logic [3:0]      valid;
  logic            any_valid;
  logic            multi_valid;
  logic [XLEN+1:0] sel;
  ex_src_e         sel_src;
  logic [XLEN-1:0] sel_r;

  always_comb begin
    valid       = {~div_bubble_i, ~mul_bubble_i, ~bu_bubble_i, ~alu_bubble_i};
    any_valid   = |valid;
    multi_valid = ($countones(valid) > 1);
    sel         = prio_sel(valid[0], valid[1], valid[2], valid[3],
                           alu_r_i, bu_r_i, mul_r_i, div_r_i);
    sel_src     = ex_src_e'(sel[XLEN+1:XLEN]);
    sel_r       = sel[XLEN-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PASS;
      ex_r_q      <= '0;
      ex_src_q    <= SRC_ALU;
      ex_bubble_q <= 1'b1;
      ex_stall_q  <= 1'b0;
      ex_err_q    <= 1'b0;
      ex_cnt_q    <= '0;
      hold_r_q    <= '0;
      hold_src_q  <= SRC_ALU;
    end else begin
      unique case (state_q)
        ST_PASS: begin
          if (multi_valid) ex_err_q <= 1'b1;
          if (!mem_stall_i) begin
            ex_bubble_q <= ~any_valid;
            if (any_valid) begin
              ex_r_q   <= sel_r;
              ex_src_q <= sel_src;
              ex_cnt_q <= ex_cnt_q + CNT_W'(1);
            end
          end else if (any_valid) begin
            hold_r_q   <= sel_r;
            hold_src_q <= sel_src;
            ex_stall_q <= 1'b1;
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Units should be stalled here; anything valid is a protocol error and is dropped.
          if (any_valid) ex_err_q <= 1'b1;
          if (!mem_stall_i) begin
            ex_r_q      <= hold_r_q;
            ex_src_q    <= hold_src_q;
            ex_bubble_q <= 1'b0;
            ex_stall_q  <= 1'b0;
            ex_cnt_q    <= ex_cnt_q + CNT_W'(1);
            state_q     <= ST_PASS;
          end
        end
        default: state_q <= ST_PASS;
      endcase
    end
  end

  assign ex_r_o      = ex_r_q;
  assign ex_src_o    = ex_src_q;
  assign ex_bubble_o = ex_bubble_q;
  assign ex_stall_o  = ex_stall_q;
  assign ex_err_o    = ex_err_q;
  assign ex_cnt_o    = ex_cnt_q;

endmodule

// File: doc/riscv_ex_result_collect.md
RISCV_EX_RESULT_COLLECT -- requirements
Module: riscv_ex_result_collect

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning integer datapath width.
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning width of the delivered-result counter.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port mem_stall_i, input, 1 bit: the downstream memory stage cannot accept a result this cycle.
REQ-006 The block SHALL have ports alu_bubble_i/alu_r_i, bu_bubble_i/bu_r_i, mul_bubble_i/mul_r_i and div_bubble_i/div_r_i, inputs, 1 bit and XLEN bits each: per-unit result, valid when its bubble is low.
REQ-007 The block SHALL have port ex_r_o, output, XLEN bits: registered result to the memory stage.
REQ-008 The block SHALL have port ex_bubble_o, output, 1 bit: ex_r_o is not valid.
REQ-009 The block SHALL have port ex_src_o, output, 2 bits: unit that produced ex_r_o (0=ALU, 1=BU, 2=MUL, 3=DIV).
REQ-010 The block SHALL have port ex_stall_o, output, 1 bit: registered stall request to the execute units.
REQ-011 The block SHALL have port ex_err_o, output, 1 bit: sticky protocol-error flag.
REQ-012 The block SHALL have port ex_cnt_o, output, CNT_W bits: count of delivered results.

Function
REQ-013 The block SHALL treat a source as valid when its bubble input is 0; any_valid is the OR of all valid sources.
REQ-014 The block SHALL select among valid sources with fixed priority MUL > DIV > BU > ALU.
REQ-015 The block SHALL implement a two-state machine with states ST_PASS and ST_HOLD; the reset state is ST_PASS.
REQ-016 In ST_PASS with mem_stall_i=0, the block SHALL, on the next edge, load ex_bubble_o with ~any_valid; when any_valid=1 it SHALL also load ex_r_o and ex_src_o with the selected source. Latency is 1 cycle.
REQ-017 In ST_PASS with mem_stall_i=0 and any_valid=0, ex_r_o and ex_src_o SHALL hold their values.
REQ-018 In ST_PASS with mem_stall_i=1, the block SHALL hold ex_r_o, ex_bubble_o and ex_src_o.
REQ-019 In ST_PASS with mem_stall_i=1 and any_valid=1, the block SHALL capture the selected result and source into a one-entry hold buffer, set ex_stall_o=1, and go to ST_HOLD.
REQ-020 In ST_HOLD with mem_stall_i=1, the block SHALL keep all outputs and the hold buffer unchanged, with ex_stall_o=1.
REQ-021 In ST_HOLD with mem_stall_i=0, the block SHALL, on the next edge, load ex_r_o and ex_src_o from the hold buffer, set ex_bubble_o=0 and ex_stall_o=0, and return to ST_PASS; inputs SHALL be ignored in that cycle.
REQ-022 The block SHALL set ex_err_o (sticky until reset) when more than one source is valid in the same cycle, or when any source is valid while in ST_HOLD; the extra result is dropped.
REQ-023 ex_cnt_o SHALL increment by 1 on each edge at which ex_bubble_o is loaded with 0, and SHALL wrap from all-ones to 0.
REQ-024 ex_stall_o SHALL be driven only from a register, with no combinational path from any input.

Reset
REQ-025 When rst_i=1 at a clock edge, the block SHALL set: state ST_PASS; ex_bubble_o=1; ex_stall_o=0; ex_err_o=0; ex_cnt_o=0; ex_r_o=0; ex_src_o=0; hold buffer cleared.
REQ-026 A reset asserted in ST_HOLD SHALL discard the held result without delivering it.
REQ-027 Reset SHALL take priority over all other events in the same cycle.

Structure
REQ-028 The ex_src encoding and the ST_PASS/ST_HOLD enumeration SHALL be defined in riscv_state_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the priority selector SHALL be a function inside the module.

Verification
REQ-030 Directed test, single result: mem_stall_i=0, mul_bubble_i=0, mul_r_i=0x0000_1234 for one cycle -> next cycle ex_r_o=0x1234, ex_src_o=2, ex_bubble_o=0, ex_cnt_o=1; the following cycle ex_bubble_o=1.
REQ-031 Directed test, stalled capture: mem_stall_i=1 for 3 cycles while div_r_i=0xDEAD_BEEF is valid in the first cycle -> ex_stall_o=1 from the next cycle; one cycle after mem_stall_i drops, ex_r_o=0xDEADBEEF, ex_src_o=3, ex_bubble_o=0, ex_stall_o=0.
REQ-032 Directed test, collision: alu_r_i=5 and mul_r_i=7 both valid in the same cycle -> ex_r_o=7, ex_src_o=2, ex_err_o=1 and remaining 1 until reset.
REQ-033 Directed test, counter wrap: with CNT_W=4, deliver 17 results -> ex_cnt_o=1.
REQ-034 Directed test, reset while holding: hold a result in ST_HOLD, then assert rst_i for one cycle -> ex_bubble_o=1, ex_stall_o=0, and the held value never appears on ex_r_o.
